fwd_hazard_unit: RTL

- Parametrised successor to the fixed 2-port, 3-way EX operand forwarding muxes.
- Tracks in-flight register writes in a STAGES-deep shift register (index 0 = EX, 1 = MEM, …, STAGES-1 = WB).
- For each of NUM_RD EX-stage source operands, selects the youngest ready producer.
- Detects load-use hazards at ID and issues the stall/bubble; sits between the ID/EX pipeline register and the ALU operand inputs.

---
 rtl/fwd_hazard_unit_pkg.sv | 17 +
 rtl/fwd_hazard_unit_port_sel.sv | 41 ++++
 rtl/fwd_hazard_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and constants for the EX operand forwarding / load-use hazard unit.
package fwd_hazard_unit_pkg;

   localparam int unsigned DEFAULT_REG_AW = 5;
   // Tracking entries store rd at this fixed width; narrower REG_AW values are zero-extended.
   localparam int unsigned REG_AW_MAX     = 8;
   localparam int unsigned ZERO_REG       = 0;
   localparam int unsigned SEL_RF         = 0;

   typedef struct packed {
      logic                  v;
      logic                  wen;
      logic                  load;
      logic [REG_AW_MAX-1:0] rd;
   } trk_entry_t;

endpackage

// File: rtl/fwd_hazard_unit_port_sel.sv
// Per-operand forwarding select: youngest matching producer, ready check and data mux.
module fwd_port_sel
   import fwd_hazard_unit_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_AW     = DEFAULT_REG_AW,
   parameter int unsigned STAGES     = 3,
   parameter int unsigned LOAD_READY = 2,
   localparam int unsigned SELW      = $clog2(STAGES)
)(
   input  trk_entry_t        ent [STAGES],
   input  logic [REG_AW-1:0] rs,
   input  logic [XLEN-1:0]   reg_data,
   input  logic [STAGES*XLEN-1:0] stage_data,
   output logic [SELW-1:0]   fwd_sel,
   output logic [XLEN-1:0]   fwd_data,
   output logic              not_ready
);

   always_comb begin : match_mux
      logic found;
      found     = 1'b0;
      fwd_sel   = SELW'(SEL_RF);
      fwd_data  = reg_data;
      not_ready = 1'b0;
      // Entry 0 is still executing, so the search starts at MEM.
      for (int unsigned i = 1; i < STAGES; i++) begin
         if (!found && ent[i].v && ent[i].wen && (rs != REG_AW'(ZERO_REG)) &&
             (ent[i].rd == REG_AW_MAX'(rs))) begin
            found = 1'b1;
            if (!ent[i].load || (i >= LOAD_READY)) begin
               fwd_sel  = SELW'(i);
               fwd_data = stage_data[i*XLEN +: XLEN];
            end else begin
               not_ready = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// In-flight write tracking, load-use stall generation and per-port operand forwarding.
module fwd_hazard_unit
   import fwd_hazard_unit_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_AW     = DEFAULT_REG_AW,
   parameter int unsigned NUM_RD     = 2,
   parameter int unsigned STAGES     = 3,
   parameter int unsigned LOAD_READY = 2,
   localparam int unsigned SELW      = $clog2(STAGES)
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     id_valid,
   input  logic                     id_wen,
   input  logic                     id_is_load,
   input  logic [REG_AW-1:0]        id_rd,
   input  logic [NUM_RD*REG_AW-1:0] id_rs,
   input  logic                     flush,
   input  logic [NUM_RD*XLEN-1:0]   ex_reg_data,
   input  logic [STAGES*XLEN-1:0]   stage_data,
   output logic [NUM_RD*XLEN-1:0]   fwd_data,
   output logic [NUM_RD*SELW-1:0]   fwd_sel,
   output logic                     stall,
   output logic                     hazard_err
);

   trk_entry_t        entry_q [STAGES];
   trk_entry_t        entry_d [STAGES];
   logic [REG_AW-1:0] ex_rs_q [NUM_RD];
   logic [REG_AW-1:0] ex_rs_d [NUM_RD];
   logic              hazard_err_q, hazard_err_d;
   logic [NUM_RD-1:0] port_not_ready;
   logic              issue;

   // A younger writer of the same rd decides; only a load at index < LOAD_READY-1 stalls.
   always_comb begin : stall_logic
      logic              found;
      logic              hit;
      logic [REG_AW-1:0] rs;
      hit = 1'b0;
      for (int unsigned p = 0; p < NUM_RD; p++) begin
         found = 1'b0;
         rs    = id_rs[p*REG_AW +: REG_AW];
         for (int unsigned j = 0; j + 1 < LOAD_READY; j++) begin
            if (!found && entry_q[j].v && entry_q[j].wen && (rs != REG_AW'(ZERO_REG)) &&
                (entry_q[j].rd == REG_AW_MAX'(rs))) begin
               found = 1'b1;
               if (entry_q[j].load) hit = 1'b1;
            end
         end
      end
      stall = id_valid && !flush && hit;
   end

   assign issue = id_valid && !stall && !flush;

   always_comb begin
      entry_d[0] = '0;
      if (issue) begin
         entry_d[0].v    = 1'b1;
         entry_d[0].wen  = id_wen;
         entry_d[0].load = id_is_load;
         entry_d[0].rd   = REG_AW_MAX'(id_rd);
      end
      for (int unsigned i = 1; i < STAGES; i++) entry_d[i] = entry_q[i-1];
      for (int unsigned p = 0; p < NUM_RD; p++) begin
         ex_rs_d[p] = issue ? id_rs[p*REG_AW +: REG_AW] : ex_rs_q[p];
      end
      // A bubble in EX carries stale source registers, so it cannot raise the error.
      hazard_err_d = hazard_err_q || (entry_q[0].v && (|port_not_ready));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < STAGES; i++) entry_q[i] <= '0;
         for (int unsigned p = 0; p < NUM_RD; p++) ex_rs_q[p] <= '0;
         hazard_err_q <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < STAGES; i++) entry_q[i] <= entry_d[i];
         for (int unsigned p = 0; p < NUM_RD; p++) ex_rs_q[p] <= ex_rs_d[p];
         hazard_err_q <= hazard_err_d;
      end
   end

   assign hazard_err = hazard_err_q;

   for (genvar p = 0; p < NUM_RD; p++) begin : g_port
      fwd_port_sel #(
         .XLEN       (XLEN),
         .REG_AW     (REG_AW),
         .STAGES     (STAGES),
         .LOAD_READY (LOAD_READY)
      ) u_sel (
         .ent        (entry_q),
         .rs         (ex_rs_q[p]),
         .reg_data   (ex_reg_data[p*XLEN +: XLEN]),
         .stage_data (stage_data),
         .fwd_sel    (fwd_sel[p*SELW +: SELW]),
         .fwd_data   (fwd_data[p*XLEN +: XLEN]),
         .not_ready  (port_not_ready[p])
      );
   end

endmodule
